// File: rtl/jt49_bus_regs.sv
// YM2149 PSG register file and BDIR/BC1 bus front end.
// Define JT49_FULL_READBACK_EN for full 8-bit readback of R0-R13 (YM2149); otherwise reads are masked (AY-3-8910).
module jt49_bus_regs #(
  parameter logic [3:0] CHIP_ADDR = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bdir,
  input  logic        bc1,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [7:0]  io_a_in,
  input  logic [7:0]  io_b_in,
  output logic [7:0]  io_a_out,
  output logic [7:0]  io_b_out,
  output logic [11:0] period_a,
  output logic [11:0] period_b,
  output logic [11:0] period_c,
  output logic [4:0]  noise_period,
  output logic [7:0]  mixer,
  output logic [4:0]  vol_a,
  output logic [4:0]  vol_b,
  output logic [4:0]  vol_c,
  output logic [15:0] env_period,
  output logic [3:0]  env_shape,
  output logic        env_restart
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_LATCH = 2'b11
  } bus_st_e;

  bus_st_e    bus_st;
  bus_st_e    prev_st_q, prev_st_d;
  logic [3:0] addr_q, addr_d;
  logic       sel_q, sel_d;
  logic [7:0] dout_q, dout_d;
  logic       env_restart_q, env_restart_d;
  logic [7:0] raw_q [16];
  logic [7:0] raw_d [16];
  logic [7:0] rd_val;
  logic       entry;

  assign bus_st = bus_st_e'({bdir, bc1});
  assign entry  = (bus_st != prev_st_q);

  // Ports R14/R15 read the pins when configured as inputs (mixer bit clear).
  always_comb begin
    rd_val = raw_q[addr_q];
    case (addr_q)
      4'd14: rd_val = raw_q[7][6] ? raw_q[14] : io_a_in;
      4'd15: rd_val = raw_q[7][7] ? raw_q[15] : io_b_in;
`ifdef JT49_FULL_READBACK_EN
      default: rd_val = raw_q[addr_q];
`else
      4'd1, 4'd3, 4'd5, 4'd13: rd_val = {4'h0, raw_q[addr_q][3:0]};
      4'd6, 4'd8, 4'd9, 4'd10: rd_val = {3'h0, raw_q[addr_q][4:0]};
      default: rd_val = raw_q[addr_q];
`endif
    endcase
  end

  always_comb begin
    prev_st_d     = bus_st;
    addr_d        = addr_q;
    sel_d         = sel_q;
    raw_d         = raw_q;
    env_restart_d = 1'b0;
    dout_d        = (bus_st == ST_READ && sel_q) ? rd_val : 8'hFF;
    if (entry && bus_st == ST_LATCH) begin
      if (din[7:4] == CHIP_ADDR) begin
        addr_d = din[3:0];
        sel_d  = 1'b1;
      end else begin
        sel_d  = 1'b0;
      end
    end
    if (entry && bus_st == ST_WRITE && sel_q) begin
      raw_d[addr_q] = din;
      env_restart_d = (addr_q == 4'd13);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_st_q     <= ST_IDLE;
      addr_q        <= 4'd0;
      sel_q         <= 1'b1;
      dout_q        <= 8'hFF;
      env_restart_q <= 1'b0;
      for (int i = 0; i < 16; i++) raw_q[i] <= 8'h00;
    end else begin
      prev_st_q     <= prev_st_d;
      addr_q        <= addr_d;
      sel_q         <= sel_d;
      dout_q        <= dout_d;
      env_restart_q <= env_restart_d;
      for (int i = 0; i < 16; i++) raw_q[i] <= raw_d[i];
    end
  end

  assign dout         = dout_q;
  assign env_restart  = env_restart_q;
  assign period_a     = {raw_q[1][3:0], raw_q[0]};
  assign period_b     = {raw_q[3][3:0], raw_q[2]};
  assign period_c     = {raw_q[5][3:0], raw_q[4]};
  assign noise_period = raw_q[6][4:0];
  assign mixer        = raw_q[7];
  assign vol_a        = raw_q[8][4:0];
  assign vol_b        = raw_q[9][4:0];
  assign vol_c        = raw_q[10][4:0];
  assign env_period   = {raw_q[12], raw_q[11]};
  assign env_shape    = raw_q[13][3:0];
  assign io_a_out     = raw_q[14];
  assign io_b_out     = raw_q[15];

endmodule

// File: tb/tb_jt49_bus_regs.sv
// Self-checking bench for jt49_bus_regs: bus-level reference model plus directed literal checks.
module tb_jt49_bus_regs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bdir = 1'b0, bc1 = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic [7:0]  io_a_in = 8'h00, io_b_in = 8'h00;
  logic [7:0]  io_a_out, io_b_out;
  logic [11:0] period_a, period_b, period_c;
  logic [4:0]  noise_period;
  logic [7:0]  mixer;
  logic [4:0]  vol_a, vol_b, vol_c;
  logic [15:0] env_period;
  logic [3:0]  env_shape;
  logic        env_restart;

  int checks = 0;
  int errors = 0;

  jt49_bus_regs #(.CHIP_ADDR(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .bdir(bdir), .bc1(bc1), .din(din), .dout(dout),
    .io_a_in(io_a_in), .io_b_in(io_b_in), .io_a_out(io_a_out), .io_b_out(io_b_out),
    .period_a(period_a), .period_b(period_b), .period_c(period_c),
    .noise_period(noise_period), .mixer(mixer), .vol_a(vol_a), .vol_b(vol_b), .vol_c(vol_c),
    .env_period(env_period), .env_shape(env_shape), .env_restart(env_restart)
  );

  always #5 clk = ~clk;

  // Reference model: register image and bus bookkeeping
  logic [7:0] m_raw [16];
  logic [3:0] m_addr;
  logic       m_sel;
  logic [1:0] m_prev;
  logic [7:0] m_dout;
  logic       m_restart;
  bit         model_on = 1'b0;

  localparam logic [1:0] IDLE = 2'b00, READ = 2'b01, WRITE = 2'b10, LATCH = 2'b11;

  function automatic logic [7:0] model_read(input logic [3:0] a);
    logic [7:0] v;
    v = m_raw[a];
    if (a == 4'd14) return m_raw[7][6] ? m_raw[14] : io_a_in;
    if (a == 4'd15) return m_raw[7][7] ? m_raw[15] : io_b_in;
`ifndef JT49_FULL_READBACK_EN
    if (a == 1 || a == 3 || a == 5 || a == 13) return v & 8'h0F;
    if (a == 6 || a == 8 || a == 9 || a == 10) return v & 8'h1F;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_raw[i] = 8'h00;
    m_addr = 4'd0; m_sel = 1'b1; m_prev = IDLE; m_dout = 8'hFF; m_restart = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] st, input logic [7:0] d);
    m_dout    = (st == READ && m_sel) ? model_read(m_addr) : 8'hFF;
    m_restart = 1'b0;
    if (st != m_prev) begin
      if (st == LATCH) begin
        if (d[7:4] == 4'd0) begin m_addr = d[3:0]; m_sel = 1'b1; end
        else m_sel = 1'b0;
      end
      if (st == WRITE && m_sel) begin
        m_raw[m_addr] = d;
        m_restart = (m_addr == 4'd13);
      end
    end
    m_prev = st;
  endtask

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      cmp("dout", 16'(dout), 16'(m_dout));
      cmp("env_restart", 16'(env_restart), 16'(m_restart));
      cmp("period_a", 16'(period_a), 16'({m_raw[1][3:0], m_raw[0]}));
      cmp("period_b", 16'(period_b), 16'({m_raw[3][3:0], m_raw[2]}));
      cmp("period_c", 16'(period_c), 16'({m_raw[5][3:0], m_raw[4]}));
      cmp("noise_period", 16'(noise_period), 16'(m_raw[6] % 32));
      cmp("mixer", 16'(mixer), 16'(m_raw[7]));
      cmp("vol_a", 16'(vol_a), 16'(m_raw[8] % 32));
      cmp("vol_b", 16'(vol_b), 16'(m_raw[9] % 32));
      cmp("vol_c", 16'(vol_c), 16'(m_raw[10] % 32));
      cmp("env_period", env_period, {m_raw[12], m_raw[11]});
      cmp("env_shape", 16'(env_shape), 16'(m_raw[13] % 16));
      cmp("io_a_out", 16'(io_a_out), 16'(m_raw[14]));
      cmp("io_b_out", 16'(io_b_out), 16'(m_raw[15]));
    end
  end

  // Called at posedge+1: drive one bus cycle, let the edge sample it, then advance the model.
  task automatic cyc(input logic [1:0] st, input logic [7:0] d);
    {bdir, bc1} = st;
    din = d;
    @(posedge clk);
    #1;
    model_step(st, d);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] v);
    cyc(LATCH, {4'h0, a});
    cyc(IDLE, 8'h00);
    cyc(WRITE, v);
    cyc(IDLE, 8'h00);
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [7:0] v);
    cyc(LATCH, {4'h0, a});
    cyc(READ, 8'h00);
    v = dout;
  endtask

  logic [7:0] rv;
  int pulses;
  logic [7:0] vals [16] = '{8'h34, 8'hF2, 8'h8B, 8'h5C, 8'h07, 8'hA9, 8'hE3, 8'h3F,
                            8'hFD, 8'h2A, 8'h91, 8'h4D, 8'hB6, 8'h7E, 8'hC3, 8'h18};

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_on = 1'b1;
    #1;
    cmp("rst_dout", 16'(dout), 16'hFF);
    cmp("rst_noise", 16'(noise_period), 16'h0);
    cmp("rst_restart", 16'(env_restart), 16'h0);
    cmp("rst_period_a", 16'(period_a), 16'h0);
    @(posedge clk); #1;

    // Noise period write and masked readback
    wr_reg(4'd6, 8'hFF);
    cmp("noise_1f", 16'(noise_period), 16'h1F);
    cyc(READ, 8'h00);
`ifdef JT49_FULL_READBACK_EN
    cmp("noise_rd", 16'(dout), 16'hFF);
`else
    cmp("noise_rd", 16'(dout), 16'h1F);
`endif
    cyc(IDLE, 8'h00);

    // Held write produces one restart pulse; a repeat write pulses again
    for (int rep = 0; rep < 2; rep++) begin
      cyc(LATCH, 8'h0D);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
        cyc(WRITE, 8'h0A);
        if (env_restart) pulses++;
      end
      cyc(IDLE, 8'h00);
      if (env_restart) pulses++;
      cmp("restart_pulses", 16'(pulses), 16'd1);
      cmp("env_shape_a", 16'(env_shape), 16'hA);
    end

    // LATCH straight into WRITE
    cyc(LATCH, 8'h00); cyc(WRITE, 8'h34); cyc(IDLE, 8'h00);
    cyc(LATCH, 8'h01); cyc(WRITE, 8'hF2); cyc(IDLE, 8'h00);
    cmp("period_a_234", 16'(period_a), 16'h234);

    // Foreign chip address deselects: write ignored, reads FF
    cyc(LATCH, 8'h17); cyc(WRITE, 8'h55); cyc(IDLE, 8'h00); cyc(READ, 8'h00);
    cmp("desel_rd", 16'(dout), 16'hFF);
    cmp("desel_pa", 16'(period_a), 16'h234);
    cyc(IDLE, 8'h00);

    // I/O port A readback direction
    wr_reg(4'd7, 8'h40);
    wr_reg(4'd14, 8'hAA);
    io_a_in = 8'h5C;
    rd_reg(4'd14, rv);
    cmp("r14_out", 16'(rv), 16'hAA);
    wr_reg(4'd7, 8'h00);
    rd_reg(4'd14, rv);
    cmp("r14_in", 16'(rv), 16'h5C);
    io_b_in = 8'h96;
    rd_reg(4'd15, rv);
    cmp("r15_in", 16'(rv), 16'h96);

    // Full register sweep: write all, read all (model checks every cycle)
    for (int r = 0; r < 16; r++) wr_reg(4'(r), vals[r]);
    for (int r = 0; r < 16; r++) begin
      rd_reg(4'(r), rv);
      cyc(IDLE, 8'h00);
    end
    cmp("env_period_lit", env_period, 16'hB64D);
    cmp("vol_a_lit", 16'(vol_a), 16'h1D);
    cmp("period_c_lit", 16'(period_c), 16'h907);

    // Reset during a write: nothing survives
    cyc(LATCH, 8'h00);
    {bdir, bc1} = WRITE; din = 8'h99;
    #2 rst_n = 1'b0;
    model_on = 1'b0;
    model_reset();
    @(posedge clk); #1;
    {bdir, bc1} = IDLE;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_on = 1'b1;
    #1;
    cmp("rstw_period_a", 16'(period_a), 16'h0);
    cmp("rstw_env_period", env_period, 16'h0);
    @(posedge clk); #1;
    wr_reg(4'd9, 8'h1B);
    cmp("post_rst_vol_b", 16'(vol_b), 16'h1B);
    repeat (2) cyc(IDLE, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
